// File: rtl/dpu_sequencer_if.sv
// Bundle between dpu_sequencer and its neighbours: host start/done, instruction fetch, DPU drive.
// master = the sequencer side, slave = the host / memory / DPU side.
interface dpu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] pc_base;
  logic              busy;
  logic              done;
  logic              err;
  // Fetch handshake: imem_req rises with imem_addr stable and stays high until a
  // cycle in which imem_ack is sampled high; imem_data is valid only in that cycle.
  // imem_ack while imem_req is low carries nothing and is ignored.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [23:0]       imem_data;
  logic [3:0]        dpu_a;
  logic [3:0]        dpu_b;
  logic [3:0]        dpu_r;
  logic [3:0]        dpu_n;
  logic [7:0]        dpu_mdata;
  logic [3:0]        dpu_cc;
  logic [1:0]        seq_state;

  modport master (
    input  start, pc_base, imem_ack, imem_data, dpu_cc,
    output busy, done, err, imem_req, imem_addr,
           dpu_a, dpu_b, dpu_r, dpu_n, dpu_mdata, seq_state
  );

  modport slave (
    output start, pc_base, imem_ack, imem_data, dpu_cc,
    input  busy, done, err, imem_req, imem_addr,
           dpu_a, dpu_b, dpu_r, dpu_n, dpu_mdata, seq_state
  );
endinterface

// File: rtl/dpu_sequencer.sv
// Microsequencer fetching 24-bit words and holding each DPU op for EXEC_CYC cycles.
// Optional instruction watchdog is enabled by defining DPU_SEQ_WDOG_EN.
module dpu_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int EXEC_CYC   = 2,
  parameter int WDOG_LIMIT = 255
) (
  input  logic           clk,
  input  logic           rst,
  dpu_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  localparam logic [3:0] OP_HALT   = 4'hE;
  localparam logic [3:0] OP_BRANCH = 4'hF;

  if (EXEC_CYC < 1 || EXEC_CYC > 15 || WDOG_LIMIT < 1) begin : g_param_check
    $error("dpu_sequencer: EXEC_CYC must be 1..15 and WDOG_LIMIT at least 1");
  end

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [3:0]          cc_reg;
  logic [3:0]          exec_cnt;

  logic [3:0]          op;
  logic [3:0]          mask;
  logic                taken;
  logic [ADDR_W+7:0]   target_wide;
  logic [ADDR_W-1:0]   target;
  logic                wdog_trip;

  assign op          = bus.imem_data[23:20];
  assign mask        = bus.imem_data[19:16];
  assign taken       = bus.imem_data[15] ? ((cc_reg & mask) == 4'd0)
                                         : ((cc_reg & mask) != 4'd0);
  // Immediate is zero-extended (or truncated) to the address width.
  assign target_wide = {{ADDR_W{1'b0}}, bus.imem_data[7:0]};
  assign target      = target_wide[ADDR_W-1:0];

  assign bus.imem_addr = pc;
  assign bus.seq_state = state;

`ifdef DPU_SEQ_WDOG_EN
  localparam int SW = $clog2(WDOG_LIMIT + 1);
  logic [SW-1:0] steps;
  assign wdog_trip = (steps == SW'(WDOG_LIMIT));
`else
  assign wdog_trip = 1'b0;
  assign bus.err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= '0;
      cc_reg        <= '0;
      exec_cnt      <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.imem_req  <= 1'b0;
      bus.dpu_a     <= '0;
      bus.dpu_b     <= '0;
      bus.dpu_r     <= '0;
      bus.dpu_n     <= '0;
      bus.dpu_mdata <= '0;
`ifdef DPU_SEQ_WDOG_EN
      steps         <= '0;
      bus.err       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pc           <= bus.pc_base;
            cc_reg       <= '0;
            bus.busy     <= 1'b1;
            bus.imem_req <= 1'b1;
            state        <= FETCH;
`ifdef DPU_SEQ_WDOG_EN
            steps        <= '0;
            bus.err      <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (!bus.imem_req) begin
            // One-cycle bubble after a branch before re-requesting.
            bus.imem_req <= 1'b1;
          end else if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            if (wdog_trip) begin
`ifdef DPU_SEQ_WDOG_EN
              bus.err  <= 1'b1;
`endif
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
`ifdef DPU_SEQ_WDOG_EN
              steps <= steps + SW'(1);
`endif
              if (op == OP_HALT) begin
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                state    <= DONE;
              end else if (op == OP_BRANCH) begin
                pc <= taken ? target : pc + ADDR_W'(1);
              end else begin
                bus.dpu_n     <= op;
                bus.dpu_a     <= bus.imem_data[19:16];
                bus.dpu_b     <= bus.imem_data[15:12];
                bus.dpu_r     <= bus.imem_data[11:8];
                bus.dpu_mdata <= bus.imem_data[7:0];
                exec_cnt      <= 4'(EXEC_CYC - 1);
                state         <= EXEC;
              end
            end
          end
        end
        EXEC: begin
          if (exec_cnt == 4'd0) begin
            cc_reg       <= bus.dpu_cc;
            pc           <= pc + ADDR_W'(1);
            bus.imem_req <= 1'b1;
            state        <= FETCH;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpu_sequencer.sv
// Bench for dpu_sequencer: directed vector table, hand sequences and random programs
// checked against an instruction-level interpreter of the program memory.
module tb_dpu_sequencer;
  localparam int ADDR_W     = 8;
  localparam int EXEC_CYC   = 2;
  localparam int WDOG_LIMIT = 3;
`ifdef DPU_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif
  localparam logic [23:0] HALT_W = 24'hE00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpu_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  dpu_sequencer #(.ADDR_W(ADDR_W), .EXEC_CYC(EXEC_CYC), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- shared state ----------------
  int total = 0;
  int bad   = 0;
  logic [23:0] mem [256];
  int   stall       = 0;
  bit   rand_lat    = 1'b0;
  bit   spur        = 1'b0;
  bit   cc_force_en = 1'b1;
  logic [3:0] cc_force = 4'h0;

  logic [ADDR_W-1:0] fetch_log[$];
  logic [23:0]       dpu_log[$];
  int                done_cnt = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [23:0]       exp_dpu_q[$];
  bit                exp_err;

  // DPU stand-in: condition codes are a simple function of the selected fields.
  assign bus.dpu_cc = cc_force_en ? cc_force : ((bus.dpu_a + bus.dpu_b) ^ bus.dpu_n);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [23:0] dpu_now();
    return {bus.dpu_n, bus.dpu_a, bus.dpu_b, bus.dpu_r, bus.dpu_mdata};
  endfunction

  // ---------------- instruction memory responder ----------------
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) bus.imem_ack = 1'b0;
      else if (bus.imem_req && !bus.imem_ack) begin
        if (stall > 0) stall--;
        else begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem[bus.imem_addr];
          if (rand_lat) stall = $urandom_range(0, 2);
        end
      end else if (!bus.imem_req && spur && ($urandom_range(0, 3) == 0)) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = 24'($urandom);
      end else bus.imem_ack = 1'b0;
    end
  end

  // ---------------- monitor: fetch log, DPU hold, branch bubble, done ----------------
  bit pend  = 1'b0;
  bit bpend = 1'b0;
  int hold  = 0;
  logic [23:0] snap;
  always @(negedge clk) begin
    if (rst) begin
      pend  = 1'b0;
      bpend = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", 32'(bus.busy), 32'd0);
      end
      if (bpend) begin
        bpend = 1'b0;
        if (bus.busy) check("branch_bubble", 32'(bus.imem_req), 32'd0);
      end
      if (pend && !bus.busy) pend = 1'b0;
      if (pend) begin
        if (!bus.imem_req) begin
          hold++;
          if (hold == 1) begin
            snap = dpu_now();
            dpu_log.push_back(snap);
          end else check("dpu_hold", 32'(dpu_now()), 32'(snap));
        end else begin
          check("exec_len", 32'(hold), 32'(EXEC_CYC));
          pend = 1'b0;
        end
      end
      if (bus.imem_req && bus.imem_ack) begin
        fetch_log.push_back(bus.imem_addr);
        if (bus.imem_data[23:20] == 4'hF) bpend = 1'b1;
        else if (bus.imem_data[23:20] != 4'hE) begin
          pend = 1'b1;
          hold = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = HALT_W;
  endtask

  task automatic pulse_start(input logic [7:0] base);
    fetch_log.delete();
    dpu_log.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.pc_base = base;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic run_prog(input logic [7:0] base, input int budget);
    bit seen;
    pulse_start(base);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin seen = 1'b1; break; end
    end
    if (!seen) timeout("run_done");
    @(negedge clk);
    @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  // Interpreter over mem[]: expected fetch addresses, DPU loads and err.
  task automatic model_run(input logic [7:0] base);
    logic [7:0]  pc;
    logic [3:0]  cc;
    logic [23:0] w;
    int          steps;
    bit          fin, tk;
    pc = base; cc = 4'h0; steps = 0; fin = 1'b0;
    exp_q.delete(); exp_dpu_q.delete(); exp_err = 1'b0;
    for (int g = 0; g < 1000 && !fin; g++) begin
      w = mem[pc];
      exp_q.push_back(pc);
      if (WDOG_ON && steps == WDOG_LIMIT) begin
        exp_err = 1'b1;
        fin = 1'b1;
      end else begin
        steps++;
        if (w[23:20] == 4'hE) fin = 1'b1;
        else if (w[23:20] == 4'hF) begin
          tk = w[15] ? ((cc & w[19:16]) == 4'h0) : ((cc & w[19:16]) != 4'h0);
          pc = tk ? w[7:0] : pc + 8'd1;
        end else begin
          exp_dpu_q.push_back(w);
          cc = 4'(w[19:16] + w[15:12]) ^ w[23:20];
          pc = pc + 8'd1;
        end
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  base;
    logic [23:0] w0;
    logic [23:0] w1;
    logic [3:0]  cc;
    int          n;
    logic [7:0]  a [3];
    logic [23:0] dpu;
  } vec_t;
  vec_t tbl [7];

  task automatic set_vec(input int i, input logic [7:0] base, input logic [23:0] w0, input logic [23:0] w1,
                         input logic [3:0] cc, input int n, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [23:0] dpu);
    tbl[i].base = base; tbl[i].w0 = w0; tbl[i].w1 = w1; tbl[i].cc = cc; tbl[i].n = n;
    tbl[i].a[0] = a0; tbl[i].a[1] = a1; tbl[i].a[2] = a2; tbl[i].dpu = dpu;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  ad;
    logic [7:0]  base;
    logic [7:0]  tgt;
    logic [23:0] w;
    int          len, r, nchk;
    bit          ok;

    bus.start   = 1'b0;
    bus.pc_base = '0;
    clear_mem();

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_dpu", 32'(dpu_now()), 32'd0);

    //            idx base   w0         w1         cc    n  fetch addresses     dpu load
    set_vec(0, 8'h10, 24'h0B80FF, 24'hE00000, 4'h0, 2, 8'h10, 8'h11, 8'h00, 24'h0B80FF);
    set_vec(1, 8'h30, 24'h123456, 24'hF40020, 4'h4, 3, 8'h30, 8'h31, 8'h20, 24'h123456);
    set_vec(2, 8'h30, 24'h123456, 24'hF48020, 4'h4, 3, 8'h30, 8'h31, 8'h32, 24'h123456);
    set_vec(3, 8'h40, 24'hD9A7C3, 24'hF40020, 4'h3, 3, 8'h40, 8'h41, 8'h42, 24'hD9A7C3);
    set_vec(4, 8'h40, 24'hD9A7C3, 24'hF48020, 4'h3, 3, 8'h40, 8'h41, 8'h20, 24'hD9A7C3);
    set_vec(5, 8'hFF, 24'h2AA5C3, 24'hE00000, 4'h0, 2, 8'hFF, 8'h00, 8'h00, 24'h2AA5C3);
    set_vec(6, 8'h70, 24'h5F0F11, 24'hFC0020, 4'h4, 3, 8'h70, 8'h71, 8'h20, 24'h5F0F11);

    cc_force_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      ad = tbl[i].base;
      mem[ad] = tbl[i].w0;
      ad = ad + 8'd1;
      mem[ad] = tbl[i].w1;
      cc_force = tbl[i].cc;
      run_prog(tbl[i].base, 200);
      check($sformatf("vec%0d_nfetch", i), 32'(fetch_log.size()), 32'(tbl[i].n));
      nchk = (fetch_log.size() < tbl[i].n) ? fetch_log.size() : tbl[i].n;
      for (int j = 0; j < nchk; j++)
        check($sformatf("vec%0d_fetch%0d", i, j), 32'(fetch_log[j]), 32'(tbl[i].a[j]));
      check($sformatf("vec%0d_ndpu", i), 32'(dpu_log.size()), 32'd1);
      if (dpu_log.size() > 0) check($sformatf("vec%0d_dpu", i), 32'(dpu_log[0]), 32'(tbl[i].dpu));
      check($sformatf("vec%0d_err", i), 32'(bus.err), 32'd0);
    end

    // Fetch stall: second fetch held off for 5 cycles
    clear_mem();
    mem[8'h50] = 24'h3C4D5E;
    pulse_start(8'h50);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fetch_log.size() == 1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("stall_first_ack");
    stall = 5;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.imem_req) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("stall_req_rise");
    for (int k = 0; k < 5; k++) begin
      check("stall_req", 32'(bus.imem_req), 32'd1);
      check("stall_addr", 32'(bus.imem_addr), 32'h51);
      check("stall_dpu", 32'(dpu_now()), 32'h3C4D5E);
      @(negedge clk);
    end
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("stall_done");
    check("stall_nfetch", 32'(fetch_log.size()), 32'd2);

    // Asynchronous reset in the middle of EXEC
    clear_mem();
    mem[8'h80] = 24'h7A1B2C;
    pulse_start(8'h80);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fetch_log.size() == 1) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("rstx_ack");
    @(negedge clk);
    check("rstx_dpu_loaded", 32'(dpu_now()), 32'h7A1B2C);
    #2 rst = 1'b1;
    #1;
    check("rstx_busy", 32'(bus.busy), 32'd0);
    check("rstx_done", 32'(bus.done), 32'd0);
    check("rstx_req", 32'(bus.imem_req), 32'd0);
    check("rstx_dpu", 32'(dpu_now()), 32'd0);
    check("rstx_addr", 32'(bus.imem_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstx_no_done", 32'(done_cnt), 32'd0);
    check("rstx_idle_req", 32'(bus.imem_req), 32'd0);

    // Watchdog: branch-to-self runs until the instruction budget is spent
    if (WDOG_ON) begin
      clear_mem();
      mem[8'h60] = 24'hF08060;
      run_prog(8'h60, 200);
      check("wdog_err", 32'(bus.err), 32'd1);
      check("wdog_nfetch", 32'(fetch_log.size()), 32'(WDOG_LIMIT + 1));
      for (int j = 0; j < fetch_log.size(); j++) check("wdog_addr", 32'(fetch_log[j]), 32'h60);
    end

    // Random programs: forward branches only, so every program terminates
    cc_force_en = 1'b0;
    rand_lat    = 1'b1;
    spur        = 1'b1;
    for (int t = 0; t < 40; t++) begin
      clear_mem();
      base = 8'($urandom);
      len  = $urandom_range(4, 12);
      for (int i = 0; i < len; i++) begin
        ad = base + 8'(i);
        r  = $urandom_range(0, 9);
        if (i == len - 1 || (i > 0 && r == 9)) w = {4'hE, 20'($urandom)};
        else if (i > 0 && r >= 6) begin
          tgt = base + 8'($urandom_range(i + 1, len - 1));
          w = {4'hF, 4'($urandom), 1'($urandom), 7'($urandom), tgt};
        end else w = {4'($urandom_range(0, 13)), 20'($urandom)};
        mem[ad] = w;
      end
      model_run(base);
      run_prog(base, 400);
      check("rnd_nfetch", 32'(fetch_log.size()), 32'(exp_q.size()));
      nchk = (fetch_log.size() < exp_q.size()) ? fetch_log.size() : exp_q.size();
      for (int j = 0; j < nchk; j++) check("rnd_fetch", 32'(fetch_log[j]), 32'(exp_q[j]));
      check("rnd_ndpu", 32'(dpu_log.size()), 32'(exp_dpu_q.size()));
      nchk = (dpu_log.size() < exp_dpu_q.size()) ? dpu_log.size() : exp_dpu_q.size();
      for (int j = 0; j < nchk; j++) check("rnd_dpu", 32'(dpu_log[j]), 32'(exp_dpu_q[j]));
      check("rnd_err", 32'(bus.err), 32'(exp_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench did not finish in time");
  end

endmodule
